line_feed_arb: RTL

- Shares the 4-element line input buffer between two element sources: req0, the external input stream, and req1, the on-chip pattern/replay source.
- Grants are line-atomic. Once a source wins, it owns the buffer for exactly LINE_LEN accepted elements.
- Arbitration between lines is round-robin. A downstream hold signal blocks the start of new lines.
- Emits a registered element stream for the buffer's data_in/valid pins, plus line-completion status.

---
 rtl/line_feed_arb.sv | 102 ++++++++++
 1 files changed

// File: rtl/line_feed_arb.sv
// Round-robin, line-atomic arbiter feeding the shared line input buffer from
// two element sources; emits a registered element stream plus line status.
module line_feed_arb #(
    parameter int DW       = 2,
    parameter int LINE_LEN = 4,
    parameter int LCW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [DW-1:0]  req0_data,
    output logic           req0_ack,
    input  logic           req1_valid,
    input  logic [DW-1:0]  req1_data,
    output logic           req1_ack,
    input  logic           hold,
    output logic           buf_valid,
    output logic [DW-1:0]  buf_data,
    output logic           line_done,
    output logic           line_src,
    output logic           busy,
    output logic [LCW-1:0] line_count
);

    localparam int CW = $clog2(LINE_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(LINE_LEN - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] elem_cnt;
    logic          rr_ptr;
    logic          accept;
    logic          last;
    logic          owner;
    logic [DW-1:0] acc_data;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        req0_ack  = 1'b0;
        req1_ack  = 1'b0;
        accept    = 1'b0;
        owner     = 1'b0;
        acc_data  = req0_data;
        case (state)
            IDLE: begin
                // Arbitration only; the first element is taken in the OWNx state.
                if (!hold && (req0_valid || req1_valid)) begin
                    if (req0_valid && req1_valid)
                        state_nxt = rr_ptr ? OWN1 : OWN0;
                    else
                        state_nxt = req1_valid ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                req0_ack = req0_valid;
                accept   = req0_valid;
            end
            OWN1: begin
                owner    = 1'b1;
                req1_ack = req1_valid;
                accept   = req1_valid;
                acc_data = req1_data;
            end
            default: state_nxt = IDLE;
        endcase
        last = accept && (elem_cnt == LAST_CNT);
        if (last)
            state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            elem_cnt   <= '0;
            rr_ptr     <= 1'b0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            line_done  <= 1'b0;
            line_src   <= 1'b0;
            line_count <= '0;
        end else begin
            state     <= state_nxt;
            buf_valid <= accept;
            line_done <= last;
            if (accept) begin
                buf_data <= acc_data;
                elem_cnt <= last ? '0 : elem_cnt + CW'(1);
            end
            if (last) begin
                rr_ptr     <= ~owner;
                line_src   <= owner;
                line_count <= line_count + LCW'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
